uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Parallel-in, serial-out UART transmitter at the output of the matrix-vector multiplier. It accepts one result bus of R signed W_Y_OUT-bit outputs through a valid/ready handshake. It slices the bus into N_WORDS bytes and sends each byte on `tx` as a fixed-length packet: start bit, data LSB first, then high stop/padding bits. It is the last stage before the chip's `tx` pin and produces exactly the frame the system bench samples.

## Interface
- `CLOCKS_PER_PULSE`, default 4, clock cycles per UART bit; must be at least 2.
- `BITS_PER_WORD`, default 8, data bits per packet.
- `PACKET_SIZE`, default 13, total bits per packet: 1 start, BITS_PER_WORD data, rest stop/padding; must be at least BITS_PER_WORD+2.
- `R`, default 8, number of output elements.
- `W_Y_OUT`, default 16, width of each output element.
- `W_BUS` (localparam) = R*W_Y_OUT; must be a multiple of BITS_PER_WORD.
- `N_WORDS` (localparam) = W_BUS/BITS_PER_WORD, 16 by default.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `s_valid`  in  1  `s_data` holds a result.
- `s_ready`  out  1  the block accepts a result this cycle.
- `s_data`  in  W_BUS  result bus; element r is at [r*W_Y_OUT +: W_Y_OUT].
- `tx`  out  1  serial line, idle high.

## Operation
- The block has three states:
  - IDLE: `s_ready`=1, `tx`=1.
  - SEND: shifts out the packets.
  - LOAD: present only with prefetch enabled; see Configuration.
- Handshake: a transfer happens on a rising edge where `s_valid` and `s_ready` are both 1. `s_data` is registered at that edge and then goes to SEND. `s_data` is ignored at every other edge.
- Word order: word w = captured[w*BITS_PER_WORD +: BITS_PER_WORD], sent in order w = 0 .. N_WORDS-1. Each element therefore goes out as little-endian bytes, element 0 first.
- Packet bit order: bit 0 = 0 (start), bits 1..BITS_PER_WORD = data LSB first, remaining bits = 1.
- Counters:
  - pulse counter: 0..CLOCKS_PER_PULSE-1
  - bit counter: 0..PACKET_SIZE-1
  - word counter: 0..N_WORDS-1
  - The pulse counter wraps into a bit advance, and the bit counter wraps into a word advance.
- When the last pulse of the last bit of word N_WORDS-1 completes, the block returns to IDLE.
- `tx` is a register output and never glitches.
- Reset values: `tx`=1, `s_ready`=1, all counters 0, state IDLE, data registers 0.
- Reset asserted mid-frame: `tx` goes to 1 immediately. The partial frame is abandoned and the captured data is discarded. After reset release the block is in IDLE and re-sends nothing.
- `s_valid` deasserting while `s_ready`=0 is legal and has no effect.

## Timing
- Accept edge at cycle t: `tx` falls to 0 (start of word 0) in cycle t+1.
- Every bit is held for exactly CLOCKS_PER_PULSE cycles.
- Packets follow each other with no gap.
- Frame length is N_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE cycles; 832 cycles with default parameters.
- Without prefetch, `s_ready` is 0 from cycle t+1 until the frame ends. It returns to 1 in the first cycle after the last padding bit, with `tx`=1.
- The earliest next start bit is therefore one cycle after `s_ready` rises plus the accept edge, so at least one idle-high cycle separates frames.

## Configuration
- Macro: `UART_TX_PREFETCH_EN`.
- Defined:
  - Adds a one-entry holding register and `s_ready` = !hold_full, so a result can be accepted while SEND is in progress.
  - At the end of a frame with the holding register full, the block passes through LOAD: one cycle with `tx`=1, moving the held data to the shift source and clearing hold_full.
  - The block then starts the next start bit in the following cycle.
  - An accept in the same cycle as LOAD goes into the just-cleared holding register.
- Undefined: no holding register; behaviour is exactly as described in Timing.

## Structure
- Shared package `uart_pkg` holds:
  - the default constants: CLOCKS_PER_PULSE, BITS_PER_WORD, PACKET_SIZE, R, W_Y_OUT;
  - the derived constants W_BUS and N_WORDS;
  - the state enum `tx_state_e` {IDLE, SEND, LOAD}.
- Sub-module `uart_tx_packet`: takes one BITS_PER_WORD word with start/done, contains the pulse and bit counters, and drives the registered `tx`.
- The top module holds the data register(s), the word counter, and the handshake.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles, then release; check `tx`=1 and `s_ready`=1 with no transitions for 50 cycles.
- Single frame: s_data[7:0]=0xA5, other bytes 0x00.
  - `tx`, sampled at mid-bit, reads 0,1,0,1,0,0,1,0,1,1,1,1,1 for word 0.
  - Each of the following 15 words reads 0, eight 0s, then 1,1,1,1.
  - Total frame is 832 cycles.
- Element packing: element 0 = 16'hFFF3 (-13), element 7 = 16'h0040.
  - Byte 0 = 0xF3, byte 1 = 0xFF, byte 14 = 0x40, byte 15 = 0x00.
  - Reconstructed elements match the inputs.
- Back-pressure: hold `s_valid`=1 with new data during SEND; it is not captured (no prefetch).
  - `s_ready` rises the cycle after the last padding bit.
  - The second frame's start bit appears 2 cycles after the last padding bit ends.
- Reset mid-frame: assert `rstn`=0 in the middle of word 5.
  - `tx`=1 within the same cycle.
  - After release there is no further start bit until a new handshake.
- With `UART_TX_PREFETCH_EN`: accept a second frame at word 3 of the first.
  - `s_ready`=0 until the LOAD cycle.
  - Exactly one idle-high cycle separates the frames.
  - Both frames decode correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART transmit path.
package uart_pkg;

  localparam int unsigned CLOCKS_PER_PULSE = 4;
  localparam int unsigned BITS_PER_WORD    = 8;
  localparam int unsigned PACKET_SIZE      = 13;
  localparam int unsigned R                = 8;
  localparam int unsigned W_Y_OUT          = 16;
  localparam int unsigned W_BUS            = R * W_Y_OUT;
  localparam int unsigned N_WORDS          = W_BUS / BITS_PER_WORD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    LOAD = 2'd2
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Valid/ready result-bus handshake between the multiplier and the UART serializer.
interface uart_tx_serializer_if #(
  parameter int unsigned W_BUS = uart_pkg::W_BUS
);
  logic             s_valid;
  logic             s_ready;
  logic [W_BUS-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/uart_tx_packet.sv
// Shifts one word out as a fixed-length packet: start bit, data LSB first, stop/padding.
module uart_tx_packet #(
  parameter int unsigned CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = uart_pkg::BITS_PER_WORD,
  parameter int unsigned PACKET_SIZE      = uart_pkg::PACKET_SIZE
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start_i,
  input  logic [BITS_PER_WORD-1:0] word_i,
  output logic                     tx_o,
  output logic                     done_c_o
);
  import uart_pkg::*;

  localparam int unsigned PW = cnt_w(CLOCKS_PER_PULSE);
  localparam int unsigned BW = cnt_w(PACKET_SIZE);

  logic [PW-1:0] pulse_q, pulse_d;
  logic [BW-1:0] bit_q, bit_d, bit_nxt_c;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          last_pulse_c, last_bit_c, next_val_c;

  assign last_pulse_c = (pulse_q == PW'(CLOCKS_PER_PULSE - 1));
  assign last_bit_c   = (bit_q == BW'(PACKET_SIZE - 1));
  assign bit_nxt_c    = bit_q + BW'(1);
  assign done_c_o     = busy_q & last_pulse_c & last_bit_c;
  assign tx_o         = tx_q;

  // Value of packet bit bit_q+1: data bit bit_q while inside the word, else padding.
  always_comb begin
    next_val_c = 1'b1;
    for (int unsigned i = 0; i < BITS_PER_WORD; i++) begin
      if (bit_q == BW'(i)) next_val_c = word_i[i];
    end
  end

  always_comb begin
    pulse_d = pulse_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    if (start_i) begin
      busy_d  = 1'b1;
      pulse_d = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
    end else if (busy_q) begin
      if (last_pulse_c) begin
        pulse_d = '0;
        if (last_bit_c) begin
          busy_d = 1'b0;
          bit_d  = '0;
          tx_d   = 1'b1;
        end else begin
          bit_d = bit_nxt_c;
          tx_d  = next_val_c;
        end
      end else begin
        pulse_d = pulse_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_q <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      pulse_q <= pulse_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Captures one result bus and sends it as N_WORDS back-to-back UART packets.
// Optional one-entry prefetch buffer enabled by defining UART_TX_PREFETCH_EN.
module uart_tx_serializer #(
  parameter int unsigned CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = uart_pkg::BITS_PER_WORD,
  parameter int unsigned PACKET_SIZE      = uart_pkg::PACKET_SIZE,
  parameter int unsigned R                = uart_pkg::R,
  parameter int unsigned W_Y_OUT          = uart_pkg::W_Y_OUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  uart_tx_serializer_if.slave   s,
  output logic                  tx
);
  import uart_pkg::*;

  localparam int unsigned W_BUS   = R * W_Y_OUT;
  localparam int unsigned N_WORDS = W_BUS / BITS_PER_WORD;
  localparam int unsigned WW      = cnt_w(N_WORDS);

  tx_state_e                state_q, state_d;
  logic [W_BUS-1:0]         data_q, data_d;
  logic [WW-1:0]            word_q, word_d;
  logic                     ready_q, ready_d;
  logic                     accept_c, pkt_start_c, pkt_done_c, last_word_c;
  logic [BITS_PER_WORD-1:0] pkt_word_c;
`ifdef UART_TX_PREFETCH_EN
  logic [W_BUS-1:0]         hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
`endif

  assign accept_c    = s.s_valid & ready_q;
  assign s.s_ready   = ready_q;
  assign last_word_c = (word_q == WW'(N_WORDS - 1));
  assign pkt_word_c  = BITS_PER_WORD'(data_q >> (32'(word_q) * BITS_PER_WORD));

  // Next-state, word sequencing and handshake.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    word_d      = word_q;
    pkt_start_c = 1'b0;
`ifdef UART_TX_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          data_d      = s.s_data;
          word_d      = '0;
          pkt_start_c = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
`ifdef UART_TX_PREFETCH_EN
        if (accept_c) begin
          hold_d      = s.s_data;
          hold_full_d = 1'b1;
        end
`endif
        if (pkt_done_c) begin
          if (!last_word_c) begin
            word_d      = word_q + WW'(1);
            pkt_start_c = 1'b1;
          end else begin
            word_d  = '0;
            state_d = IDLE;
`ifdef UART_TX_PREFETCH_EN
            if (hold_full_q) begin
              state_d     = LOAD;
              data_d      = hold_q;
              hold_full_d = 1'b0;
            end
`endif
          end
        end
      end
      LOAD: begin
        word_d      = '0;
        pkt_start_c = 1'b1;
        state_d     = SEND;
`ifdef UART_TX_PREFETCH_EN
        if (accept_c) begin
          hold_d      = s.s_data;
          hold_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_PREFETCH_EN
    ready_d = !hold_full_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      data_q  <= '0;
      word_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

`ifdef UART_TX_PREFETCH_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  uart_tx_packet #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
    .BITS_PER_WORD    (BITS_PER_WORD),
    .PACKET_SIZE      (PACKET_SIZE)
  ) u_packet (
    .clk      (clk),
    .rstn     (rstn),
    .start_i  (pkt_start_c),
    .word_i   (pkt_word_c),
    .tx_o     (tx),
    .done_c_o (pkt_done_c)
  );

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: decodes tx at mid-bit and checks frames and timing.
module tb_uart_tx_serializer;
  import uart_pkg::*;

`ifdef UART_TX_PREFETCH_EN
  localparam logic BUSY_RDY = 1'b1;
`else
  localparam logic BUSY_RDY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic tx;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  uart_tx_serializer_if #(.W_BUS(W_BUS)) bus ();

  uart_tx_serializer dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_low(input int budget, output int n);
    n = 0;
    while (tx !== 1'b0 && n < budget) begin tick(); n++; end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (bus.s_ready !== 1'b1 && n < budget) begin tick(); n++; end
  endtask

  // Called in the first cycle of word 0's start bit; ends at mid-bit of the last padding bit.
  task automatic rx_frame(input int inj_w, input logic [W_BUS-1:0] inj_d,
                          output logic [W_BUS-1:0] d, output logic ok,
                          output logic [PACKET_SIZE-1:0] p0, output logic inj_rdy);
    logic bitv;
    d = '0; ok = 1'b1; p0 = '0; inj_rdy = 1'bx;
    repeat (2) tick();
    for (int w = 0; w < int'(N_WORDS); w++) begin
      for (int b = 0; b < int'(PACKET_SIZE); b++) begin
        bitv = tx;
        if (w == 0) p0[b] = bitv;
        if (b == 0 && bitv !== 1'b0) ok = 1'b0;
        else if (b > int'(BITS_PER_WORD) && bitv !== 1'b1) ok = 1'b0;
        else if (b >= 1 && b <= int'(BITS_PER_WORD)) d[w*int'(BITS_PER_WORD) + b - 1] = bitv;
        if (w == inj_w && b == 0) begin
          bus.s_valid = 1'b1; bus.s_data = inj_d;
          tick();
          bus.s_valid = 1'b0;
          inj_rdy = bus.s_ready;
          repeat (3) tick();
        end else if (!(w == int'(N_WORDS) - 1 && b == int'(PACKET_SIZE) - 1)) begin
          repeat (4) tick();
        end
      end
    end
  endtask

  logic [W_BUS-1:0]       d, pk, bdat;
  logic                   ok, ir;
  logic [PACKET_SIZE-1:0] p0;
  int                     n, acc, bad;

  initial begin
    rstn = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;

    // Reset and idle line
    repeat (2) tick();
    check("rst_tx_during", tx, 1);
    rstn = 1'b1;
    check("rst_ready", bus.s_ready, 1);
    bad = 0;
    repeat (50) begin tick(); if (tx !== 1'b1 || bus.s_ready !== 1'b1) bad++; end
    check("idle_50_cycles", bad, 0);

    // Single frame, byte 0 = 0xA5
    bus.s_data = 128'hA5; bus.s_valid = 1'b1;
    tick(); acc = cyc; bus.s_valid = 1'b0;
    check("a5_start_latency", tx, 0);
    check("a5_ready_busy", bus.s_ready, BUSY_RDY);
    rx_frame(-1, '0, d, ok, p0, ir);
    check("a5_word0_bits", p0, 13'b1_1111_0100_1010);
    check("a5_data", d, 128'hA5);
    check("a5_framing", ok, 1);
`ifndef UART_TX_PREFETCH_EN
    wait_ready(2000, n);
    check("a5_frame_len", cyc - acc, 832);
    check("a5_idle_tx", tx, 1);

    // Element packing with back-pressure: data held during SEND must not be captured
    pk   = {16'h0040, 96'h0, 16'hFFF3};
    bdat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.s_data = pk; bus.s_valid = 1'b1;
    tick(); acc = cyc;
    bus.s_data = bdat;
    check("bp_ready_low", bus.s_ready, 0);
    rx_frame(-1, '0, d, ok, p0, ir);
    check("pk_byte0", d[7:0], 8'hF3);
    check("pk_byte1", d[15:8], 8'hFF);
    check("pk_byte14", d[119:112], 8'h40);
    check("pk_byte15", d[127:120], 8'h00);
    check("pk_elem0", d[15:0], 16'hFFF3);
    check("pk_elem7", d[127:112], 16'h0040);
    check("pk_framing", ok, 1);
    wait_ready(2000, n);
    check("bp_ready_rise", cyc - acc, 832);
    check("bp_gap_cycles", n, 2);
    check("bp_idle_tx", tx, 1);
    tick();
    bus.s_valid = 1'b0;
    check("bp_next_start", tx, 0);
    rx_frame(-1, '0, d, ok, p0, ir);
    check("bp_second_data", d, bdat);
    check("bp_second_framing", ok, 1);
    wait_ready(2000, n);
`else
    tick(); tick();
    // Prefetch: second frame accepted during word 3 of the first
    pk   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    bdat = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0F0F;
    bus.s_data = pk; bus.s_valid = 1'b1;
    tick(); bus.s_valid = 1'b0;
    check("pf_start1", tx, 0);
    rx_frame(3, bdat, d, ok, p0, ir);
    check("pf_ready_after_accept", ir, 0);
    check("pf_first_data", d, pk);
    check("pf_first_framing", ok, 1);
    tick();
    check("pf_ready_before_load", bus.s_ready, 0);
    tick();
    check("pf_load_ready", bus.s_ready, 1);
    check("pf_load_tx", tx, 1);
    tick();
    check("pf_start2", tx, 0);
    rx_frame(-1, '0, d, ok, p0, ir);
    check("pf_second_data", d, bdat);
    check("pf_second_framing", ok, 1);
    tick(); tick();
`endif

    // Reset in the middle of word 5 (all-zero data, so tx is low there)
    bus.s_data = '0; bus.s_valid = 1'b1;
    tick(); bus.s_valid = 1'b0;
    repeat (286) tick();
    check("mr_pre_reset_tx", tx, 0);
    #2 rstn = 1'b0;
    #1;
    check("mr_async_tx", tx, 1);
    check("mr_async_ready", bus.s_ready, 1);
    tick(); tick();
    rstn = 1'b1;
    bad = 0;
    repeat (200) begin tick(); if (tx !== 1'b1) bad++; end
    check("mr_no_resend", bad, 0);
    check("mr_ready_after", bus.s_ready, 1);

    // Recovery frame after reset
    pk = 128'h5A5A_0000_FFFF_1234_8001_7F7F_C3C3_00FF;
    bus.s_data = pk; bus.s_valid = 1'b1;
    tick(); bus.s_valid = 1'b0;
    wait_low(4, n);
    check("rec_start_latency", n, 0);
    rx_frame(-1, '0, d, ok, p0, ir);
    check("rec_data", d, pk);
    check("rec_framing", ok, 1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
